// File: rtl/m_control_pkg.sv
// m_control_pkg: ALU opcodes, MC bit positions and instruction field offsets
package m_control_pkg;
  localparam int OPC_W = 3;
  typedef enum logic [OPC_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
  } alu_op_e;
  localparam int MC_MEM = 0;
  localparam int MC_REG = 1;
  localparam int MEMB_LO = 0;
  function automatic int opb_lo(int aw);
    return aw;
  endfunction
  function automatic int aluc_lo(int aw);
    return 2 * aw;
  endfunction
  function automatic int opa_lo(int aw, int cw);
    return 2 * aw + cw;
  endfunction
  function automatic int mc_lo(int aw, int cw);
    return 3 * aw + cw;
  endfunction
endpackage

// File: rtl/m_alu_p.sv
// m_alu_p: combinational eight-operation ALU
module m_alu_p import m_control_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] y_o
);
  // result select; shifts use only the low five bits of B
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLL: y_o = a_i << b_i[4:0];
      ALU_SRL: y_o = a_i >> b_i[4:0];
      ALU_SLT: y_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/m_control_seq.sv
// m_control_seq: two-stage pipelined control datapath with RAW interlock and back-pressure
module m_control_seq import m_control_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ALUC_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2+3*ADDR_W+ALUC_W-1:0]  instruccion,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             salidaOperacion,
  output logic                          zeroflag,
  output logic                          out_valid,
  input  logic                          out_ready
);
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int OPB_LO  = opb_lo(ADDR_W);
  localparam int ALUC_LO = aluc_lo(ADDR_W);
  localparam int OPA_LO  = opa_lo(ADDR_W, ALUC_W);
  localparam int MC_LO   = mc_lo(ADDR_W, ALUC_W);

  logic [DATA_W-1:0] rf_q   [DEPTH];
  logic [DATA_W-1:0] memb_q [DEPTH];

  logic [1:0]        in_mc;
  logic [ADDR_W-1:0] in_opa, in_opb, in_memb;
  logic [ALUC_W-1:0] in_aluc;

  logic              s1_v_q;
  logic [1:0]        s1_mc_q;
  logic [ADDR_W-1:0] s1_opa_q, s1_memb_q;
  logic [ALUC_W-1:0] s1_aluc_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;

  logic              s2_v_q;
  logic [1:0]        s2_mc_q;
  logic [ADDR_W-1:0] s2_opa_q, s2_memb_q;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;

  logic [DATA_W-1:0] alu_y;
  logic retire, s2_free, s1_adv, accept, hazard;

  assign in_mc   = instruccion[MC_LO +: 2];
  assign in_opa  = instruccion[OPA_LO +: ADDR_W];
  assign in_aluc = instruccion[ALUC_LO +: ALUC_W];
  assign in_opb  = instruccion[OPB_LO +: ADDR_W];
  assign in_memb = instruccion[MEMB_LO +: ADDR_W];

  assign retire  = s2_v_q && out_ready;
  assign s2_free = !s2_v_q || out_ready;
  assign s1_adv  = s1_v_q && s2_free;
  assign accept  = in_valid && in_ready;

  // a source register or a read-back address still owed a write by S1 or S2 blocks issue
  always_comb begin
    hazard = 1'b0;
    hazard = hazard || (s1_v_q && s1_mc_q[MC_REG] && (s1_opa_q == in_opa || s1_opa_q == in_opb));
    hazard = hazard || (s2_v_q && s2_mc_q[MC_REG] && (s2_opa_q == in_opa || s2_opa_q == in_opb));
    hazard = hazard || (in_mc == 2'b00 && s1_v_q && s1_mc_q[MC_MEM] && s1_memb_q == in_memb);
    hazard = hazard || (in_mc == 2'b00 && s2_v_q && s2_mc_q[MC_MEM] && s2_memb_q == in_memb);
  end

  assign in_ready        = !hazard && (!s1_v_q || s2_free);
  assign out_valid       = s2_v_q;
  assign salidaOperacion = s2_data_q;
  assign zeroflag        = (s2_data_q == '0);

  m_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .op_i (alu_op_e'(s1_aluc_q)),
    .y_o  (alu_y)
  );

  assign s2_data_d = (s1_mc_q == 2'b00) ? memb_q[s1_memb_q] : alu_y;

  // stage valids and the visible result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
    end else begin
      if (!s1_v_q || s2_free) s1_v_q <= accept;
      if (s2_free) s2_v_q <= s1_v_q;
      if (s1_adv) s2_data_q <= s2_data_d;
    end
  end

  // stage payloads; operands are sampled at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mc_q   <= in_mc;
      s1_opa_q  <= in_opa;
      s1_aluc_q <= in_aluc;
      s1_memb_q <= in_memb;
      s1_a_q    <= rf_q[in_opa];
      s1_b_q    <= rf_q[in_opb];
    end
    if (s1_adv) begin
      s2_mc_q   <= s1_mc_q;
      s2_opa_q  <= s1_opa_q;
      s2_memb_q <= s1_memb_q;
    end
  end

  // architectural state commits only when the consumer takes the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i]   <= '0;
        memb_q[i] <= '0;
      end
    end else if (retire) begin
      if (s2_mc_q[MC_REG]) rf_q[s2_opa_q] <= s2_data_q;
      if (s2_mc_q[MC_MEM]) memb_q[s2_memb_q] <= s2_data_q;
    end
  end
endmodule
